// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_pkg
// Description : Shared constants, state encodings and helpers for the
//               round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Request/data/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if import mux_rr_arbiter_pkg::*; ();

    logic [NREQ-1:0] req;
    logic            d0;
    logic            d1;
    logic            d2;
    logic            d3;
    logic [NREQ-1:0] grant;
    logic            s1;
    logic            s0;
    logic            valid;
    logic            data_out;

    modport master (
        output req, d0, d1, d2, d3,
        input  grant, s1, s0, valid, data_out
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output grant, s1, s0, valid, data_out
    );

endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin scan of the request vector starting
//               at ptr, optionally skipping one index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [IDX_W-1:0] ptr,
    input  wire logic             excl_en,
    input  wire logic [IDX_W-1:0] excl_idx,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand] && !(excl_en && (cand == excl_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter with bounded bursts driving the 4:1 data
//               mux select lines and a valid-gated data output.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_rr_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state_q,  state_d;
    logic [IDX_W-1:0] ptr_q,    ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [NREQ-1:0]  grant_q,  grant_d;
    logic [IDX_W-1:0] sel_q,    sel_d;
    logic             valid_q,  valid_d;

    logic             owner_req;
    logic             others_req;
    logic             keep;
    logic [IDX_W-1:0] pick_ptr;
    logic             pick_excl;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [NREQ-1:0]  d_vec;

    // While busy, the next candidate scan starts just after the owner and
    // skips it, so a release hands over on the same edge.
    always_comb begin
        pick_excl  = (state_q == BUSY);
        pick_ptr   = pick_excl ? (sel_q + IDX_W'(1)) : ptr_q;
        owner_req  = bus.req[sel_q];
        others_req = |(bus.req & ~onehot(sel_q));
        keep       = owner_req && ((cnt_q < CNT_MAX) || !others_req);
    end

    rr_pick u_rr_pick (
        .req      (bus.req),
        .ptr      (pick_ptr),
        .excl_en  (pick_excl),
        .excl_idx (sel_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found)          state_d = BUSY;
            BUSY:    if (!keep && !pick_found) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (state_q == IDLE) begin
            if (pick_found) begin
                sel_d   = pick_idx;
                grant_d = onehot(pick_idx);
                valid_d = 1'b1;
                cnt_d   = '0;
            end
        end else if (keep) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
        end else begin
            ptr_d = sel_q + IDX_W'(1);
            if (pick_found) begin
                sel_d   = pick_idx;
                grant_d = onehot(pick_idx);
                cnt_d   = '0;
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    assign d_vec        = {bus.d3, bus.d2, bus.d1, bus.d0};
    assign bus.grant    = grant_q;
    assign bus.s1       = sel_q[1];
    assign bus.s0       = sel_q[0];
    assign bus.valid    = valid_q;
    assign bus.data_out = valid_q & d_vec[sel_q];

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed self-checking bench for mux_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then check all outputs.
    task automatic apply(input string tag, input logic r, input logic [3:0] rq,
                         input logic [3:0] d, input logic [3:0] e_grant,
                         input logic e_valid, input logic [1:0] e_sel,
                         input logic e_dout);
        rst     = r;
        bus.req = rq;
        {bus.d3, bus.d2, bus.d1, bus.d0} = d;
        @(posedge clk);
        #1;
        chk({tag, ".grant"}, 32'(bus.grant), 32'(e_grant));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(e_valid));
        chk({tag, ".sel"},   32'({bus.s1, bus.s0}), 32'(e_sel));
        chk({tag, ".dout"},  32'(bus.data_out), 32'(e_dout));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        {bus.d3, bus.d2, bus.d1, bus.d0} = 4'b0000;

        // Reset with everyone requesting
        apply("rst0", 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
        apply("rst1", 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Lone requester holds indefinitely
        for (int i = 0; i < 10; i++)
            apply("single", 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);

        // Owner 2 drops; scan from 3 finds 0, then 4-cycle bursts alternate
        for (int i = 0; i < 4; i++)
            apply("burst_a", 1'b0, 4'b0011, 4'b1010, 4'b0001, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            apply("burst_b", 1'b0, 4'b0011, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        apply("burst_c", 1'b0, 4'b0011, 4'b1010, 4'b0001, 1'b1, 2'd0, 1'b0);

        // Release handovers with no dead cycle
        apply("hand01", 1'b0, 4'b1010, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        apply("hand13", 1'b0, 4'b1000, 4'b1010, 4'b1000, 1'b1, 2'd3, 1'b1);

        // Idle return: selects hold last owner, data gated off
        apply("idle0", 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd3, 1'b0);
        apply("idle1", 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd3, 1'b0);

        // ptr wrapped to 0: full rotation 0,1,2,3
        for (int i = 0; i < 4; i++)
            apply("rot0", 1'b0, 4'b1111, 4'b0110, 4'b0001, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            apply("rot1", 1'b0, 4'b1111, 4'b0110, 4'b0010, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++)
            apply("rot2", 1'b0, 4'b1111, 4'b0110, 4'b0100, 1'b1, 2'd2, 1'b1);
        apply("rot3", 1'b0, 4'b1111, 4'b0110, 4'b1000, 1'b1, 2'd3, 1'b0);

        // Mid-burst reset, then ptr restarts at 0
        apply("midrst", 1'b1, 4'b1111, 4'b0110, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            apply("post_a", 1'b0, 4'b1001, 4'b1001, 4'b0001, 1'b1, 2'd0, 1'b1);
        apply("post_b", 1'b0, 4'b1001, 4'b1001, 4'b1000, 1'b1, 2'd3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the team's 4:1 single-bit data mux among four requesters. It samples a 4-bit request vector, grants one requester at a time with a bounded burst length, and drives the mux select pair (s1,s0) accordingly. It also outputs the selected data bit gated by a valid flag. The block sits in front of the mux datapath and is the only agent allowed to drive its select lines.

## Interface
- MAX_BURST, 4, max consecutive cycles one owner may hold the grant while another requester waits (legal range 1..7)
- CNT_W, 3, width of burst counter; must satisfy 2^CNT_W > MAX_BURST
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; req[i] = requester i wants the mux
- d0, d1, d2, d3  input  1 each  data bits of requesters 0..3
- grant  output  4  registered one-hot grant, or all-zero when idle
- s1, s0  output  1 each  registered mux select; {s1,s0} = index of owner
- valid  output  1  registered; high while grant is non-zero
- data_out  output  1  combinational: d[{s1,s0}] when valid, else 0

## Operation
- States: IDLE (no owner), BUSY (owner = {s1,s0}).
- Internal regs: ptr[1:0] (next priority start), cnt[CNT_W-1:0] (cycles held by current owner).
- Pick function: first i with req[i]=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req != 0, then owner <= pick, grant <= onehot(pick), valid <= 1, cnt <= 0, go to BUSY. Otherwise hold.
- BUSY, keep condition: req[owner]=1 and (cnt < MAX_BURST-1 or no other req bit set). Action: stay, cnt <= cnt+1 saturating at MAX_BURST-1.
- BUSY, release condition: req[owner]=0, or burst expired with another req pending. Action: ptr <= owner+1 mod 4. The pick is evaluated with that new ptr and excludes the old owner.
  - If an eligible requester exists, switch to it on the same edge (no idle bubble) and set cnt <= 0.
  - Otherwise go to IDLE with grant <= 0 and valid <= 0.
- A lone requester never expires; it holds indefinitely, with cnt saturated.
- {s1,s0} holds the last owner index in IDLE; data_out is forced to 0 by valid.
- Invariant: grant is one-hot or zero. grant == onehot({s1,s0}) whenever valid = 1.

## Timing
- Reset values: grant=4'b0000, s1=0, s0=0, valid=0, data_out=0, ptr=0, cnt=0, state IDLE.
- Latency: req rising at edge N is granted at edge N+1, visible after N+1.
- Handover: owner drops req before edge N; the new grant is visible after edge N. One cycle total, no dead cycle.
- Burst expiry with MAX_BURST=4: owner holds for exactly 4 cycles of grant, then rotates.
- Simultaneous requests: resolved purely by ptr order.
  - From reset with req=4'b1111, grant order is 0,1,2,3,0...
- Reset asserted during BUSY: at the next edge all outputs return to reset values, regardless of req.
- data_out has no registered stage. Its path is d inputs or registered selects to output, through one 4:1 mux.

## Structure
- Shared package/header: constants NREQ=4 and IDX_W=2, plus state encodings IDLE=1'b0 and BUSY=1'b1.
- One natural sub-module: rr_pick.
  - Combinational; inputs req[3:0], ptr[1:0], excl_en, excl_idx[1:0].
  - Outputs found and idx[1:0].
- Top-level holds the FSM, ptr, cnt, output registers and the data_out select.
- Estimated size: about 150–220 lines of RTL.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0000, valid=0, {s1,s0}=00, data_out=0 throughout.
- Single requester: req=4'b0100 held 10 cycles, d2=1 -> grant=0100 from the 1st edge on and never rotates; {s1,s0}=10; data_out=1.
- Burst expiry: req=4'b0011 held, MAX_BURST=4 -> grant=0001 for 4 cycles, 0010 for 4 cycles, then 0001 again.
- Release handover: owner 1 drops req while req[3]=1 -> grant goes 0010 to 1000 in one edge, valid stays 1; ptr wraps to 0 after owner 3 releases.
- Idle return plus data gating: all req drop -> grant=0000, valid=0, data_out=0 even with d0..d3=1111, {s1,s0} holds last index.
- Mid-burst reset: rst=1 for 1 cycle while grant=1000 -> next edge grant=0000. After rst falls with req=4'b1001, grant=0001 (ptr reset to 0).
